rr_priority_encoder: RTL

//  Parametrised, registered N-input priority encoder with selectable fixed or

---
 rtl/enc_pkg.sv | 16 +
 rtl/priority_pick.sv | 50 +++++
 rtl/rr_priority_encoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_pick.sv
// Combinational winner search: first set request at or above ptr_i, wrapping.
module priority_pick
  import enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]        req_i,
  input  logic [clog2(N)-1:0] ptr_i,
  output logic                any_o,
  output logic [clog2(N)-1:0] win_o,
  output logic [N-1:0]        win_oh_o
);

  localparam int IDX_W = clog2(N);

  logic [N-1:0]   hi_mask_s;
  logic [2*N-1:0] dbl_s;
  logic           found_s;

  // Upper half sees every request, so the search wraps back to bit 0.
  always_comb begin
    hi_mask_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      hi_mask_s[i] = (i >= int'(ptr_i));
    end
    dbl_s    = {req_i, req_i & hi_mask_s};
    any_o    = |req_i;
    found_s  = 1'b0;
    win_o    = {IDX_W{1'b0}};
    win_oh_o = {N{1'b0}};
    for (int i = 0; i < 2 * N; i++) begin
      if (!found_s && dbl_s[i]) begin
        found_s = 1'b1;
        if (i >= N) begin
          win_o = IDX_W'(i - N);
        end else begin
          win_o = IDX_W'(i);
        end
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      win_oh_o = {{(N-1){1'b0}}, 1'b1} << win_o;
    end else begin
      win_oh_o = {N{1'b0}};
    end
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered N-input priority encoder, fixed or round-robin, with a
// valid/ready output register and a rotating search pointer.
module rr_priority_encoder
  import enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [N-1:0]        req_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [N-1:0]        grant_o,
  output logic [clog2(N)-1:0] index_o
);

  localparam int IDX_W = clog2(N);

  logic             valid_q, valid_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             load_s;
  logic             any_s;
  logic [IDX_W-1:0] win_s;
  logic [N-1:0]     win_oh_s;
  logic [IDX_W-1:0] ptr_pick_s;

  // Fixed mode always searches from bit 0.
  always_comb begin
    if (MODE == MODE_RR) begin
      ptr_pick_s = ptr_q;
    end else begin
      ptr_pick_s = {IDX_W{1'b0}};
    end
  end

  priority_pick #(.N(N)) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_pick_s),
    .any_o    (any_s),
    .win_o    (win_s),
    .win_oh_o (win_oh_s)
  );

  assign load_s = enable_i && (!valid_q || ready_i);

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    valid_d = valid_q;
    grant_d = grant_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    if (load_s) begin
      if (any_s) begin
        valid_d = 1'b1;
        grant_d = win_oh_s;
        index_d = win_s;
        if (MODE == MODE_RR) begin
          if (win_s == IDX_W'(N - 1)) begin
            ptr_d = {IDX_W{1'b0}};
          end else begin
            ptr_d = win_s + IDX_W'(1);
          end
        end else begin
          ptr_d = {IDX_W{1'b0}};
        end
      end else begin
        valid_d = 1'b0;
        grant_d = {N{1'b0}};
        index_d = {IDX_W{1'b0}};
      end
    end else if (valid_q && !ready_i) begin
      valid_d = valid_q;
      grant_d = grant_q;
      index_d = index_q;
    end else begin
      valid_d = 1'b0;
      grant_d = {N{1'b0}};
      index_d = {IDX_W{1'b0}};
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      grant_q <= {N{1'b0}};
      index_q <= {IDX_W{1'b0}};
      ptr_q   <= {IDX_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      grant_q <= grant_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o = valid_q;
  assign grant_o = grant_q;
  assign index_o = index_q;

endmodule
